// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-RAM port between an instruction cache (0) and a
// data cache (1); serialises level-held fetch/flush requests and aborts on timeout.
module cache_mem_arbiter #(
    parameter int unsigned address_space = 12,
    parameter int unsigned data_size     = 32,
    parameter int unsigned timeout       = 256
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic                     fetch0,
    input  logic                     fetch1,
    input  logic                     flush0,
    input  logic                     flush1,
    input  logic [address_space-1:0] addr0,
    input  logic [address_space-1:0] addr1,
    input  logic [data_size-1:0]     wdata0,
    input  logic [data_size-1:0]     wdata1,
    output logic                     fetch_ack0,
    output logic                     fetch_ack1,
    output logic                     flush_ack0,
    output logic                     flush_ack1,
    output logic [data_size-1:0]     rdata0,
    output logic [data_size-1:0]     rdata1,
    output logic                     err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [address_space-1:0] mem_addr,
    output logic [data_size-1:0]     mem_wdata,
    input  logic [data_size-1:0]     mem_rdata,
    input  logic                     mem_ready
);

    typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

    localparam logic [15:0] CntLast = 16'(timeout - 1);

    state_e                   state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic                     gnt_q, gnt_d;
    logic                     op_q, op_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [address_space-1:0] addr_d;
    logic [data_size-1:0]     wdata_d, rdata0_d, rdata1_d, rd_val;
    logic                     fetch_ack0_d, fetch_ack1_d, flush_ack0_d, flush_ack1_d;
    logic                     err_d, mem_en_d, mem_we_d;
    logic                     pend0, pend1, sel;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        addr_d       = mem_addr;
        wdata_d      = mem_wdata;
        rdata0_d     = rdata0;
        rdata1_d     = rdata1;
        fetch_ack0_d = 1'b0;
        fetch_ack1_d = 1'b0;
        flush_ack0_d = 1'b0;
        flush_ack1_d = 1'b0;
        err_d        = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        pend0        = fetch0 | flush0;
        pend1        = fetch1 | flush1;
        // On a tie the requester that did not win last time is chosen.
        sel          = (pend0 && pend1) ? ~last_grant_q : pend1;
        rd_val       = mem_ready ? mem_rdata : '0;

        unique case (state_q)
            StIdle: begin
                if (pend0 || pend1) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    op_d         = sel ? flush1 : flush0;
                    addr_d       = sel ? addr1 : addr0;
                    wdata_d      = sel ? wdata1 : wdata0;
                    cnt_d        = '0;
                    mem_en_d     = 1'b1;
                    mem_we_d     = op_d;
                    state_d      = StMem;
                end
            end
            StMem: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_ready || cnt_q == CntLast) begin
                    state_d = StResp;
                    err_d   = ~mem_ready;
                    if (!op_q) begin
                        if (gnt_q) rdata1_d = rd_val;
                        else       rdata0_d = rd_val;
                    end
                    fetch_ack0_d = ~op_q & ~gnt_q;
                    fetch_ack1_d = ~op_q &  gnt_q;
                    flush_ack0_d =  op_q & ~gnt_q;
                    flush_ack1_d =  op_q &  gnt_q;
                end else begin
                    mem_en_d = 1'b1;
                    mem_we_d = op_q;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            op_q         <= 1'b0;
            cnt_q        <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rdata0       <= '0;
            rdata1       <= '0;
            fetch_ack0   <= 1'b0;
            fetch_ack1   <= 1'b0;
            flush_ack0   <= 1'b0;
            flush_ack1   <= 1'b0;
            err          <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            mem_addr     <= addr_d;
            mem_wdata    <= wdata_d;
            rdata0       <= rdata0_d;
            rdata1       <= rdata1_d;
            fetch_ack0   <= fetch_ack0_d;
            fetch_ack1   <= fetch_ack1_d;
            flush_ack0   <= flush_ack0_d;
            flush_ack1   <= flush_ack1_d;
            err          <= err_d;
            mem_en       <= mem_en_d;
            mem_we       <= mem_we_d;
        end
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares one main-RAM port between two direct-mapped caches (requester 0 = instruction cache, requester 1 = data cache). It accepts their level-held fetch (read-miss) and flush (write-through) requests and serialises them onto the memory bus with round-robin fairness. It returns one-cycle fetch_ack/flush_ack pulses carrying read data, and aborts memory accesses that exceed a timeout.

## Interface
Parameters:
- address_space, 12, width of all address buses
- data_size, 32, width of all data buses
- timeout, 256, max cycles in MEM before abort (≥1, ≤65535)

Ports:
- clka  in  1  clock; all state changes on rising edge
- rsta  in  1  reset, asynchronous, active-low
- fetch0 / fetch1  in  1  read request from requester 0/1, level, held until its ack
- flush0 / flush1  in  1  write request from requester 0/1, level, held until its ack
- addr0 / addr1  in  address_space  request address
- wdata0 / wdata1  in  data_size  write data (flush only)
- fetch_ack0 / fetch_ack1  out  1  one-cycle pulse, read complete, rdata valid
- flush_ack0 / flush_ack1  out  1  one-cycle pulse, write complete
- rdata0 / rdata1  out  data_size  read data, valid in fetch_ack cycle, held until next read for that requester
- err  out  1  one-cycle pulse coincident with an ack when access timed out
- mem_en  out  1  memory access active
- mem_we  out  1  1 = write, 0 = read; valid while mem_en
- mem_addr  out  address_space  latched address
- mem_wdata  out  data_size  latched write data
- mem_rdata  in  data_size  read data, sampled when mem_ready
- mem_ready  in  1  memory completion, honoured only in MEM

## Operation
- States: IDLE, MEM, RESP.
- IDLE:
  - A requester is pending if its fetch or flush is high.
  - With none pending, stay in IDLE.
  - With one pending, grant it.
  - With both pending, grant the requester ≠ last_grant.
  - On grant, latch id, op (flush has priority over fetch if both high on one requester), addr and wdata; update last_grant; clear the timeout counter; go to MEM.
- MEM:
  - mem_en=1; mem_we=op; mem_addr/mem_wdata come from the latch and stay stable throughout.
  - Counter increments each MEM cycle.
  - mem_ready=1: capture mem_rdata (reads only) into rdata of the granted requester; go to RESP, err_pending=0.
  - Else, counter == timeout-1: go to RESP, err_pending=1, rdata of the granted requester ← 0 (reads only).
- RESP:
  - Assert exactly one of fetch_ack/flush_ack for the granted requester; err=err_pending; mem_en=0.
  - Next state is IDLE unconditionally. The requester drops its request on the same edge, so it is never re-granted spuriously.
- Request deasserted after grant: the transaction completes and the ack is still pulsed.
- mem_ready outside MEM: ignored.
- Requests arriving during MEM/RESP wait; they are not lost because they are level-held.

## Timing
- Reset (rsta=0, asynchronous):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - All acks, err, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata0, rdata1 = 0; counter = 0.
  - mem_en drops immediately, mid-transaction included; no ack is issued for an aborted transaction.
- Request visible in IDLE cycle t:
  - mem_en=1 from cycle t+1.
  - mem_ready at t+1 at the earliest gives the ack in t+2, and the arbiter is back in IDLE at t+3.
  - Minimum 3 cycles per transaction.
- With mem_ready first high in MEM cycle k (k=1 is the first cycle): ack in cycle t+k+1.
- Timeout: with no ready, MEM lasts exactly timeout cycles; the ack and err arrive in the next cycle.
- Outputs are all registered; no combinational path from inputs to outputs.

## Test plan
- Single read:
  - Stimulus: fetch0=1, addr0=0x123; memory returns mem_ready with 0xDEADBEEF in the 2nd MEM cycle.
  - Required: mem_en=1, mem_we=0, mem_addr=0x123 for 2 cycles; then fetch_ack0 pulses 1 cycle with rdata0=0xDEADBEEF and err=0.
- Single write:
  - Stimulus: flush1=1, addr1=0x0F0, wdata1=0x55AA55AA; immediate ready.
  - Required: one MEM cycle with mem_we=1, mem_wdata=0x55AA55AA; then flush_ack1 pulses; rdata1 is unchanged.
- Round-robin:
  - Stimulus: fetch0 and fetch1 both held from reset through 4 transactions (each requester re-raises after its ack).
  - Required: grant order 0,1,0,1.
- Timeout:
  - Stimulus: timeout=4, fetch1=1, mem_ready never asserted.
  - Required: mem_en high exactly 4 cycles, then fetch_ack1 with err=1 and rdata1=0.
- Reset mid-MEM:
  - Stimulus: pull rsta low for 1 cycle during MEM of a write, then release.
  - Required: mem_en=0 immediately; no flush_ack; after release the still-held flush is re-granted and completes normally.
- Stray ready and dual-op:
  - Stimulus: pulse mem_ready while in IDLE; then raise fetch0 and flush0 together.
  - Required: the stray ready has no effect; a write is issued first, with flush_ack0 only.
